// File: rtl/axi_slave_stream_fifo.sv
// axi_slave_stream_fifo
// AXI4-Stream slave input buffered in a FIFO and drained by a processor
// through an AXI4-Lite register interface (DATA / STATUS / CONTROL).
// Optional feature macro: AXIS_FIFO_IRQ_EN adds the irq port and the
// programmable level threshold in CONTROL[15:8].
module axi_slave_stream_fifo #(
    parameter int C_S00_AXI_DATA_WIDTH   = 32,
    parameter int C_S00_AXI_ADDR_WIDTH   = 4,
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_FIFO_DEPTH           = 16
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
`ifdef AXIS_FIFO_IRQ_EN
    output logic                              irq,
`endif
    // stream input
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                              s00_axis_tlast,
    input  logic                              s00_axis_tvalid,
    output logic                              s00_axis_tready,
    // AXI4-Lite write address / data / response
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    // AXI4-Lite read address / data
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready
);

    localparam int W  = C_S00_AXIS_TDATA_WIDTH;
    localparam int PW = $clog2(C_FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;

    // storage: {tlast, tdata}
    logic [W:0]    mem [C_FIFO_DEPTH];
    logic [W:0]    head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty;

    logic          rst_done;       // keeps tready low until the first edge out of reset
    logic          flush_pending;  // the cycle in which the flush takes effect
    logic          underflow;
    logic [7:0]    irq_thresh;

    logic          awready_q, arready_q;
    logic          push, pop, aw_hs, ar_hs, flush_req, empty_read;
    logic [1:0]    wr_sel, rd_sel;
    logic [C_S00_AXI_DATA_WIDTH-1:0] rd_word;

    // inputs the register map does not decode
    logic unused_ok;
    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr,
                         s00_axi_araddr, s00_axi_wdata, s00_axi_wstrb};

    assign full  = (count == CW'(C_FIFO_DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // tready depends only on registered state, never on tvalid
    assign s00_axis_tready = rst_done && !full && !flush_pending;

    assign wr_sel     = s00_axi_awaddr[3:2];
    assign rd_sel     = s00_axi_araddr[3:2];
    assign push       = s00_axis_tvalid && s00_axis_tready;
    assign aw_hs      = s00_axi_awvalid && s00_axi_wvalid && awready_q;
    assign ar_hs      = s00_axi_arvalid && arready_q;
    assign empty_read = ar_hs && (rd_sel == REG_DATA) && empty;
    assign pop        = ar_hs && (rd_sel == REG_DATA) && !empty;
    assign flush_req  = aw_hs && (wr_sel == REG_CTRL) && s00_axi_wstrb[0] && s00_axi_wdata[0];

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = awready_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_bresp   = 2'b00;

    // read mux: value captured into rdata on the address handshake
    always_comb begin
        rd_word = '0;
        case (rd_sel)
            REG_DATA: if (!empty) rd_word[W-1:0] = head[W-1:0];
            REG_STAT: begin
                rd_word[0]    = empty;
                rd_word[1]    = full;
                rd_word[2]    = !empty && head[W];
                rd_word[3]    = underflow;
                rd_word[15:8] = 8'(count);
            end
            REG_CTRL: rd_word[15:8] = irq_thresh;
            default:  rd_word = '0;
        endcase
    end

    // FIFO storage, written on a stream handshake (contents need no reset)
    always_ff @(posedge ACLK) begin
        if (push) mem[wr_ptr] <= {s00_axis_tlast, s00_axis_tdata};
    end

    // pointers and occupancy; flush overrides everything in its cycle
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_pending) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // control state: startup gate, flush strobe, sticky underflow
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rst_done      <= 1'b0;
            flush_pending <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            rst_done      <= 1'b1;
            flush_pending <= flush_req;
            if (flush_pending)   underflow <= 1'b0;
            else if (empty_read) underflow <= 1'b1;
        end
    end

    // write channel: single-cycle aw/w ready, then hold bvalid until bready
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            awready_q      <= 1'b0;
            s00_axi_bvalid <= 1'b0;
        end else begin
            awready_q <= s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid && !awready_q;
            if (aw_hs)               s00_axi_bvalid <= 1'b1;
            else if (s00_axi_bready) s00_axi_bvalid <= 1'b0;
        end
    end

    // read channel: arready pulse, response registered and held until rready
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            arready_q      <= 1'b0;
            s00_axi_rvalid <= 1'b0;
            s00_axi_rdata  <= '0;
            s00_axi_rresp  <= 2'b00;
        end else begin
            arready_q <= s00_axi_arvalid && !s00_axi_rvalid && !arready_q;
            if (ar_hs) begin
                s00_axi_rvalid <= 1'b1;
                s00_axi_rdata  <= rd_word;
                s00_axi_rresp  <= empty_read ? 2'b10 : 2'b00;
            end else if (s00_axi_rready) begin
                s00_axi_rvalid <= 1'b0;
            end
        end
    end

`ifdef AXIS_FIFO_IRQ_EN
    // threshold register, byte 1 of CONTROL
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
            irq_thresh <= 8'd0;
        else if (aw_hs && (wr_sel == REG_CTRL) && s00_axi_wstrb[1])
            irq_thresh <= s00_axi_wdata[15:8];
    end

    // level interrupt, one cycle behind the occupancy it reflects
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) irq <= 1'b0;
        else          irq <= (irq_thresh != 8'd0) && (9'(count) >= {1'b0, irq_thresh});
    end
`else
    assign irq_thresh = 8'd0;
`endif

endmodule

// File: tb/tb_axi_slave_stream_fifo.sv
// Self-checking bench for axi_slave_stream_fifo: directed scenarios plus a
// randomized phase, all scored against a queue-based model of the register map.
module tb_axi_slave_stream_fifo;

    localparam int W     = 32;
    localparam int DEPTH = 16;

    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic [W-1:0] tdata = '0;
    logic         tlast = 1'b0, tvalid = 1'b0, tready;
    logic [3:0]   awaddr = '0, araddr = '0;
    logic [2:0]   awprot = '0, arprot = '0;
    logic         awvalid = 1'b0, awready, wvalid = 1'b0, wready;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic [1:0]   bresp, rresp;
    logic         bvalid, bready = 1'b0;
    logic         arvalid = 1'b0, arready;
    logic [31:0]  rdata;
    logic         rvalid, rready = 1'b0;
`ifdef AXIS_FIFO_IRQ_EN
    logic         irq;
`endif

    always #5 ACLK = ~ACLK;

    axi_slave_stream_fifo #(
        .C_S00_AXI_DATA_WIDTH(32), .C_S00_AXI_ADDR_WIDTH(4),
        .C_S00_AXIS_TDATA_WIDTH(W), .C_FIFO_DEPTH(DEPTH)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
`ifdef AXIS_FIFO_IRQ_EN
        .irq(irq),
`endif
        .s00_axis_tdata(tdata), .s00_axis_tlast(tlast),
        .s00_axis_tvalid(tvalid), .s00_axis_tready(tready),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot),
        .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot),
        .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp),
        .s00_axi_rvalid(rvalid), .s00_axi_rready(rready)
    );

    // reference model state
    logic [32:0] q[$];       // {tlast, tdata}
    logic [33:0] exp_r[$];   // {rresp, rdata} awaiting the R handshake
    bit          m_uf, m_live, m_flush, m_irq;
    logic [7:0]  m_thr;
    int          checks, errors;
    bit          hs_push, hs_ar, hs_aw, hs_r, hs_b;
    logic [31:0] last_rdata;
    logic [1:0]  last_rresp;

    task automatic model_reset();
        q.delete(); exp_r.delete();
        m_uf = 0; m_live = 0; m_flush = 0; m_irq = 0; m_thr = '0;
    endtask

    // advance one clock; score tready/irq/R/B against the model and update it
    task automatic step();
        bit p, a, w, r, b, do_pop, do_flush, nxt_irq;
        logic [32:0] entry;
        logic [31:0] ed;
        logic [1:0]  er;
        p = tvalid && tready;
        a = arvalid && arready;
        w = awvalid && wvalid && awready && wready;
        r = rvalid && rready;
        b = bvalid && bready;
        entry = {tlast, tdata};
        do_pop = 0;
        checks++;
        if (tready !== (m_live && q.size() < DEPTH && !m_flush)) begin
            errors++;
            $display("FAIL tready: got %b expected %b (model count %0d)", tready,
                     m_live && q.size() < DEPTH && !m_flush, q.size());
        end
`ifdef AXIS_FIFO_IRQ_EN
        checks++;
        if (irq !== m_irq) begin
            errors++;
            $display("FAIL irq: got %b expected %b", irq, m_irq);
        end
`endif
        if (r) begin
            checks++;
            if (exp_r.size() == 0) begin
                errors++;
                $display("FAIL rresponse: got unexpected rdata %h rresp %b", rdata, rresp);
            end else begin
                {er, ed} = exp_r.pop_front();
                if (rdata !== ed || rresp !== er) begin
                    errors++;
                    $display("FAIL rdata: got %h/%b expected %h/%b", rdata, rresp, ed, er);
                end
            end
            last_rdata = rdata;
            last_rresp = rresp;
        end
        if (b) begin
            checks++;
            if (bresp !== 2'b00) begin
                errors++;
                $display("FAIL bresp: got %b expected 00", bresp);
            end
        end
        nxt_irq = (m_thr != 0) && (q.size() >= m_thr);
        if (a) begin
            ed = '0; er = 2'b00;
            case (araddr[3:2])
                2'd0: if (q.size() == 0) begin er = 2'b10; m_uf = 1; end
                      else begin ed = q[0][31:0]; do_pop = 1; end
                2'd1: ed = {16'h0, 8'(q.size()), 4'h0, m_uf,
                            q.size() > 0 && q[0][32], q.size() == DEPTH, q.size() == 0};
                2'd2: ed = {16'h0, m_thr, 8'h0};
                default: ed = '0;
            endcase
            exp_r.push_back({er, ed});
        end
        do_flush = m_flush;
        @(posedge ACLK); #1;
        if (ARESETN) begin
            if (do_pop) void'(q.pop_front());
            if (p) q.push_back(entry);
            if (do_flush) begin q.delete(); m_uf = 0; m_flush = 0; end
            if (w && awaddr[3:2] == 2'd2) begin
                if (wstrb[0] && wdata[0]) m_flush = 1;
`ifdef AXIS_FIFO_IRQ_EN
                if (wstrb[1]) m_thr = wdata[15:8];
`endif
            end
            m_irq  = nxt_irq;
            m_live = 1;
        end
        hs_push = p; hs_ar = a; hs_aw = w; hs_r = r; hs_b = b;
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        bit ok;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (hs_aw) begin ok = 1; break; end
        end
        awvalid = 0; wvalid = 0;
        if (ok) begin
            ok = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (hs_b) begin ok = 1; break; end
            end
        end
        bready = 0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL write_timeout: addr %h got no handshake, required within 20 cycles", a);
        end
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] rr);
        bit ok;
        araddr = a; arvalid = 1; rready = 1;
        d = 'x; rr = 'x; ok = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (hs_ar) begin ok = 1; break; end
        end
        arvalid = 0;
        if (ok) begin
            ok = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (hs_r) begin ok = 1; d = last_rdata; rr = last_rresp; break; end
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL read_timeout: addr %h got no response, required within 20 cycles", a);
        end
    endtask

    task automatic push_beat(input logic [31:0] d, input logic l);
        bit ok;
        tdata = d; tlast = l; tvalid = 1; ok = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (hs_push) begin ok = 1; break; end
        end
        tvalid = 0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL push_timeout: beat %h not accepted, required within 40 cycles", d);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] rr;
        #1;
        checks++;
        if ({tready, awready, wready, arready, bvalid, rvalid, rresp, bresp} !== 10'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got tr%b aw%b w%b ar%b b%b r%b rresp%b bresp%b rdata %h, required all 0",
                     tready, awready, wready, arready, bvalid, rvalid, rresp, bresp, rdata);
        end
`ifdef AXIS_FIFO_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b required 0", irq); end
`endif
        step(); step();
        ARESETN = 1;
        step(); step();
        axi_read(4'h4, d, rr);
        checks++;
        if (d !== 32'h1 || rr !== 2'b00) begin
            errors++; $display("FAIL reset_status: got %h/%b required 00000001/00", d, rr);
        end
        axi_read(4'h8, d, rr);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_control: got %h required 0", d); end
    endtask

    task automatic test_basic();
        logic [31:0] d; logic [1:0] rr;
        push_beat(32'h11, 0); push_beat(32'h22, 0); push_beat(32'h33, 1);
        axi_read(4'h0, d, rr);
        checks++;
        if (d !== 32'h11 || rr !== 2'b00) begin errors++; $display("FAIL basic_pop1: got %h/%b required 11/00", d, rr); end
        axi_read(4'h0, d, rr);
        checks++;
        if (d !== 32'h22 || rr !== 2'b00) begin errors++; $display("FAIL basic_pop2: got %h/%b required 22/00", d, rr); end
        axi_read(4'h4, d, rr);
        checks++;
        if (d !== 32'h0000_0104) begin errors++; $display("FAIL basic_status: got %h required 00000104", d); end
        axi_read(4'h0, d, rr);
        checks++;
        if (d !== 32'h33 || rr !== 2'b00) begin errors++; $display("FAIL basic_pop3: got %h/%b required 33/00", d, rr); end
        axi_read(4'hC, d, rr);
        checks++;
        if (d !== 32'h0 || rr !== 2'b00) begin errors++; $display("FAIL reserved: got %h/%b required 0/00", d, rr); end
    endtask

    task automatic test_full();
        logic [31:0] d; logic [1:0] rr;
        int n;
        n = 0;
        tvalid = 1; tdata = $urandom; tlast = 0;
        for (int i = 0; i < 40 && n < DEPTH; i++) begin
            step();
            if (hs_push) begin n++; tdata = $urandom; tlast = $urandom_range(0, 1); end
        end
        step(); step();
        checks++;
        if (tready !== 1'b0 || n != DEPTH) begin
            errors++; $display("FAIL full_tready: got %b after %0d beats, required 0 after 16", tready, n);
        end
        tvalid = 0;
        axi_read(4'h4, d, rr);
        checks++;
        if (d[1:0] !== 2'b10 || d[15:8] !== 8'd16) begin
            errors++; $display("FAIL full_status: got %h required full=1 count=16", d);
        end
        axi_read(4'h0, d, rr);
        checks++;
        if (tready !== 1'b1) begin errors++; $display("FAIL full_release: tready got %b required 1", tready); end
        axi_write(4'h8, 32'h1, 4'h1);
    endtask

    task automatic test_underflow();
        logic [31:0] d; logic [1:0] rr;
        axi_read(4'h0, d, rr);
        checks++;
        if (d !== 32'h0 || rr !== 2'b10) begin errors++; $display("FAIL empty_read: got %h/%b required 0/10", d, rr); end
        axi_read(4'h4, d, rr);
        checks++;
        if (d !== 32'h9) begin errors++; $display("FAIL underflow_flag: got %h required 00000009", d); end
        axi_write(4'hC, 32'hFFFF_FFFF, 4'hF);
        axi_write(4'h8, 32'h1, 4'h1);
        axi_read(4'h4, d, rr);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL flush_status: got %h required 00000001", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic [1:0] rr;
        for (int i = 0; i < 4; i++) push_beat($urandom, $urandom_range(0, 1));
        araddr = 4'h0; arvalid = 1; rready = 1;
        for (int i = 0; i < 45; i++) begin
            tvalid = arready;
            tdata = $urandom; tlast = $urandom_range(0, 1);
            step();
        end
        tvalid = 0; arvalid = 0;
        for (int i = 0; i < 4; i++) step();
        axi_read(4'h4, d, rr);
        checks++;
        if (d[15:8] !== 8'd4) begin errors++; $display("FAIL b2b_count: got %0d required 4", d[15:8]); end
        axi_write(4'h8, 32'h1, 4'h1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            tvalid = $urandom_range(0, 2) != 0;
            tdata = $urandom; tlast = $urandom_range(0, 1);
            rready = $urandom_range(0, 1); bready = $urandom_range(0, 1);
            if (!arvalid && $urandom_range(0, 2) == 0) begin
                arvalid = 1;
                araddr = ($urandom_range(0, 3) == 0) ? 4'h4 : 4'h0;
                if ($urandom_range(0, 9) == 0) araddr = 4'h8;
            end
            if (!awvalid && $urandom_range(0, 39) == 0) begin
                awvalid = 1; wvalid = 1;
                awaddr = $urandom_range(0, 3) == 0 ? 4'hC : 4'h8;
                wdata = {16'h0, 8'($urandom_range(0, 12)), 7'h0, 1'($urandom_range(0, 4) == 0)};
                wstrb = 4'($urandom);
            end
            step();
            if (hs_ar) arvalid = 0;
            if (hs_aw) begin awvalid = 0; wvalid = 0; end
        end
        tvalid = 0; arvalid = 0; awvalid = 0; wvalid = 0; rready = 1; bready = 1;
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (exp_r.size() != 0) begin
            errors++; $display("FAIL random_drain: %0d read responses missing, required 0", exp_r.size());
        end
        axi_write(4'h8, 32'h1, 4'h3);
    endtask

`ifdef AXIS_FIFO_IRQ_EN
    task automatic test_irq();
        logic [31:0] d; logic [1:0] rr;
        axi_write(4'h8, 32'h0400, 4'h2);
        for (int i = 0; i < 3; i++) push_beat($urandom, 0);
        step();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_below: got %b required 0", irq); end
        push_beat($urandom, 0);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b required 0", irq); end
        step();
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_at: got %b required 1", irq); end
        axi_read(4'h0, d, rr);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_pop: got %b required 0", irq); end
        axi_write(4'h8, 32'h1, 4'h3);
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] d; logic [1:0] rr;
        for (int i = 0; i < 5; i++) push_beat($urandom, 0);
        araddr = 4'h0; arvalid = 1; rready = 0;
        for (int i = 0; i < 10 && !hs_ar; i++) step();
        arvalid = 0;
        step();
        checks++;
        if (rvalid !== 1'b1) begin errors++; $display("FAIL midrst_pending: rvalid got %b required 1", rvalid); end
        #2 ARESETN = 0;
        model_reset();
        #1;
        checks++;
        if (rvalid !== 1'b0 || tready !== 1'b0 || rdata !== 32'h0) begin
            errors++; $display("FAIL midrst_outputs: rvalid %b tready %b rdata %h, required 0/0/0", rvalid, tready, rdata);
        end
        step(); step();
        ARESETN = 1;
        step(); step();
        axi_read(4'h4, d, rr);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL midrst_status: got %h required 00000001", d); end
    endtask

    initial begin
        checks = 0; errors = 0;
        model_reset();
        test_reset();
        test_basic();
        test_full();
        test_underflow();
        test_back_to_back();
        test_random();
`ifdef AXIS_FIFO_IRQ_EN
        test_irq();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
